// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply/divide unit owning the HI/LO pair; one result bit per cycle.
// Optional sticky divide-by-zero flag output DIVZ when MULDIV_DIVZ_FLAG_EN is defined.
module ex_muldiv_unit #(
  parameter int DWL = 32
) (
  input  logic           CLK,
  input  logic           CLR_N,
  input  logic           START,
  input  logic [1:0]     OP,
  input  logic [DWL-1:0] A,
  input  logic [DWL-1:0] B,
  input  logic           ABORT,
  input  logic           WE_HI,
  input  logic           WE_LO,
  input  logic [DWL-1:0] WD,
  output logic           BUSY,
  output logic           DONE,
  output logic [DWL-1:0] HI,
  output logic [DWL-1:0] LO
`ifdef MULDIV_DIVZ_FLAG_EN
  ,
  output logic           DIVZ
`endif
);

  localparam int CW = $clog2(DWL);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic             is_div, sa, sb;
  logic [DWL-1:0]   mb;
  logic [2*DWL-1:0] acc;
  logic             launch, step, fix;
  logic             op_signed;

  function automatic logic [DWL-1:0] abs_f(input logic [DWL-1:0] x, input logic sg);
    return (sg && x[DWL-1]) ? -x : x;
  endfunction

  function automatic logic [DWL-1:0] neg1_f(input logic [DWL-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*DWL-1:0] neg2_f(input logic [2*DWL-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (START && !ABORT) state_nx = S_RUN;
      S_RUN:   if (ABORT) state_nx = S_IDLE;
               else if (count == '0) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    launch = (state == S_IDLE) && START && !ABORT;
    step   = (state == S_RUN) && !ABORT;
    fix    = (state == S_FIX) && !ABORT;
  end

  assign op_signed = ~OP[0];

  // One radix-2 step: shift-add multiply, or restoring divide on {remainder, quotient}
  logic [DWL:0]     madd, dtop, ddiff;
  logic [2*DWL-1:0] mul_nx, div_nx, acc_nx;
  always_comb begin
    madd   = {1'b0, acc[2*DWL-1:DWL]} + (acc[0] ? {1'b0, mb} : {(DWL+1){1'b0}});
    mul_nx = {madd, acc[DWL-1:1]};
    dtop   = acc[2*DWL-1:DWL-1];
    ddiff  = dtop - {1'b0, mb};
    div_nx = ddiff[DWL] ? {dtop[DWL-1:0], acc[DWL-2:0], 1'b0}
                        : {ddiff[DWL-1:0], acc[DWL-2:0], 1'b1};
    acc_nx = is_div ? div_nx : mul_nx;
  end

  // Sign correction; a zero divisor forces an all-ones quotient, remainder restores A
  logic [2*DWL-1:0] prod;
  logic [DWL-1:0]   q_fix, r_fix, hi_res, lo_res;
  always_comb begin
    prod   = neg2_f(acc, sa ^ sb);
    q_fix  = (mb == '0) ? {DWL{1'b1}} : neg1_f(acc[DWL-1:0], sa ^ sb);
    r_fix  = neg1_f(acc[2*DWL-1:DWL], sa);
    hi_res = is_div ? r_fix : prod[2*DWL-1:DWL];
    lo_res = is_div ? q_fix : prod[DWL-1:0];
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      count  <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      mb     <= '0;
      acc    <= '0;
    end else if (launch) begin
      count  <= CW'(DWL-1);
      is_div <= OP[1];
      sa     <= op_signed & A[DWL-1];
      sb     <= op_signed & B[DWL-1];
      mb     <= abs_f(B, op_signed);
      acc    <= {{DWL{1'b0}}, abs_f(A, op_signed)};
    end else if (step) begin
      count  <= count - CW'(1);
      acc    <= acc_nx;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      BUSY <= 1'b0;
      DONE <= 1'b0;
      HI   <= '0;
      LO   <= '0;
    end else begin
      BUSY <= (state_nx != S_IDLE);
      DONE <= fix;
      if (fix) begin
        HI <= hi_res;
        LO <= lo_res;
      end else if (state == S_IDLE) begin
        if (WE_HI) HI <= WD;
        if (WE_LO) LO <= WD;
      end
    end
  end

`ifdef MULDIV_DIVZ_FLAG_EN
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N)                       DIVZ <= 1'b0;
    else if (launch)                  DIVZ <= 1'b0;
    else if (fix && is_div && mb == '0) DIVZ <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed ops push expected HI/LO, a monitor checks on DONE.
module tb_ex_muldiv_unit;

  logic        CLK = 1'b0;
  logic        CLR_N;
  logic        START, ABORT, WE_HI, WE_LO;
  logic [1:0]  OP;
  logic [31:0] A, B, WD;
  logic        BUSY, DONE;
  logic [31:0] HI, LO;
`ifdef MULDIV_DIVZ_FLAG_EN
  logic        DIVZ;
`endif

  ex_muldiv_unit #(.DWL(32)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .START(START), .OP(OP), .A(A), .B(B),
    .ABORT(ABORT), .WE_HI(WE_HI), .WE_LO(WE_LO), .WD(WD),
    .BUSY(BUSY), .DONE(DONE), .HI(HI), .LO(LO)
`ifdef MULDIV_DIVZ_FLAG_EN
    , .DIVZ(DIVZ)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (CLR_N && DONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", HI, e.hi);
        chk("result_lo", LO, e.lo);
`ifdef MULDIV_DIVZ_FLAG_EN
        chk("divz_flag", DIVZ, e.dz);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                       input bit hold);
    exp_t e;
    int   n;
    e.hi = hi; e.lo = lo; e.dz = dz;
    sb.push_back(e);
    START = 1'b1; OP = op; A = a; B = b;
    tick();
    if (hold) begin
      OP = ~op; A = ~a; B = b + 32'd1;
    end else begin
      START = 1'b0;
    end
`ifdef MULDIV_DIVZ_FLAG_EN
    chk("divz_clear_on_start", DIVZ, 0);
`endif
    n = 0;
    while (BUSY && n < 100) begin
      n++;
      tick();
    end
    START = 1'b0;
    chk("busy_cycles", n, 33);
    chk("done_pulse", DONE, 1);
  endtask

  initial begin
    CLR_N = 1'b0; START = 1'b0; ABORT = 1'b0; WE_HI = 1'b0; WE_LO = 1'b0;
    OP = 2'b00; A = '0; B = '0; WD = '0;
    tick(); tick();
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    CLR_N = 1'b1;
    tick();

    issue(MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0, 1'b0);
    chk("done_single_cycle", DONE, 1);
    tick();
    chk("done_drops", DONE, 0);

    issue(MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    issue(MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0, 1'b0);
    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);

    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    issue(DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0);
    issue(DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0);
    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 1'b0);

    issue(DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b1, 1'b0);
    issue(DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
`ifdef MULDIV_DIVZ_FLAG_EN
    chk("divz_sticky", DIVZ, 1);
`endif
    issue(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 1'b0);

    // Abort at busy cycle 10: no result, HI/LO keep 0/15
    START = 1'b1; OP = MULTU; A = 32'd9; B = 32'd9;
    tick();
    START = 1'b0;
    repeat (9) tick();
    chk("abort_busy_before", BUSY, 1);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    chk("abort_busy", BUSY, 0);
    chk("abort_done", DONE, 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 15);
    repeat (40) tick();
    chk("abort_hold_lo", LO, 15);

    START = 1'b1; ABORT = 1'b1; OP = MULTU; A = 32'd2; B = 32'd2;
    tick();
    START = 1'b0; ABORT = 1'b0;
    chk("start_abort_nolaunch", BUSY, 0);
    tick();

    WE_LO = 1'b1; WD = 32'd5;
    tick();
    WE_LO = 1'b0;
    chk("mtlo_lo", LO, 5);
    chk("mtlo_hi_kept", HI, 0);
    WE_HI = 1'b1; WE_LO = 1'b1; WD = 32'd9;
    tick();
    WE_HI = 1'b0; WE_LO = 1'b0;
    chk("mt_both_hi", HI, 9);
    chk("mt_both_lo", LO, 9);

    issue(MULTU, 32'd12, 32'd12, 32'd0, 32'd144, 1'b0, 1'b1);
    tick();
    chk("held_start_ignored", BUSY, 0);

    // MTLO in the launch cycle lands first, then the op result overwrites it
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd6; e.dz = 1'b0;
      sb.push_back(e);
    end
    START = 1'b1; OP = MULTU; A = 32'd2; B = 32'd3; WE_LO = 1'b1; WD = 32'd77;
    tick();
    START = 1'b0; WE_LO = 1'b0;
    chk("mt_with_start_lo", LO, 77);
    repeat (40) tick();
    chk("mt_overwritten_lo", LO, 6);

    // Asynchronous reset mid-run, between clock edges
    START = 1'b1; OP = MULTU; A = 32'd5; B = 32'd5;
    tick();
    START = 1'b0;
    repeat (5) tick();
    #2 CLR_N = 1'b0;
    #1;
    chk("arst_busy", BUSY, 0);
    chk("arst_done", DONE, 0);
    chk("arst_hi", HI, 0);
    chk("arst_lo", LO, 0);
    #2 CLR_N = 1'b1;
    tick();
    chk("arst_no_resume", BUSY, 0);
    repeat (40) tick();
    chk("arst_no_result", LO, 0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
